// File: rtl/prng_core_if.sv
`default_nettype none
// ============================================================================
// Module  : prng_core_if
// Desc    : Wrapper-to-PRNG control/result bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface prng_core_if #(
    parameter int DAT_W = 16,
    parameter int IMM_W = 16,
    parameter int TYP_W = 2,
    parameter int DLY_W = 4
);
    logic             t_cs;
    logic             ipt_wrp_to_prng_t_sel;
    logic [TYP_W-1:0] ipt_wrp_to_prng_typ_sel;
    logic [IMM_W-1:0] ipt_wrp_to_prng_t_dat;
    logic [DLY_W-1:0] ipt_wrp_to_prng_delay;
    logic [DAT_W-1:0] opt_prng_to_wrp_dat;
    logic             opt_prng_busy;
    logic             opt_prng_done;

    modport master (
        output t_cs,
        output ipt_wrp_to_prng_t_sel,
        output ipt_wrp_to_prng_typ_sel,
        output ipt_wrp_to_prng_t_dat,
        output ipt_wrp_to_prng_delay,
        input  opt_prng_to_wrp_dat,
        input  opt_prng_busy,
        input  opt_prng_done
    );

    modport slave (
        input  t_cs,
        input  ipt_wrp_to_prng_t_sel,
        input  ipt_wrp_to_prng_typ_sel,
        input  ipt_wrp_to_prng_t_dat,
        input  ipt_wrp_to_prng_delay,
        output opt_prng_to_wrp_dat,
        output opt_prng_busy,
        output opt_prng_done
    );
endinterface
`default_nettype wire

// File: rtl/prng_core.sv
`default_nettype none
// ============================================================================
// Module  : prng_core
// Desc    : 32-bit Galois LFSR random word generator with seeding and
//           masked-rejection reduction into [0, modulus).
// Revision: 1.0 - initial release
// ============================================================================
module prng_core #(
    parameter int          DAT_W     = 16,
    parameter int          IMM_W     = 16,
    parameter int          TYP_W     = 2,
    parameter int          DLY_W     = 4,
    parameter logic [31:0] POLY      = 32'h80200003,
    parameter int          RETRY_MAX = 8
) (
    input  wire logic  clk,
    input  wire logic  reset_b,
    prng_core_if.slave bus
);
    localparam int BIT_W = $clog2(DAT_W);
    localparam int ATT_W = $clog2(RETRY_MAX + 1);

    localparam logic [TYP_W-1:0] TYP_NOP  = TYP_W'(0);
    localparam logic [TYP_W-1:0] TYP_SEED = TYP_W'(1);
    localparam logic [TYP_W-1:0] TYP_RAND = TYP_W'(2);
    localparam logic [IMM_W-1:0] SEED_XOR = IMM_W'(16'h5A5A);
    localparam logic [31:0]      LFSR_RST = 32'h00005A5A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_GEN  = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t           fsm_q,  fsm_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic             t_sel_q;
    logic [TYP_W-1:0] typ_q,  typ_d;
    logic [IMM_W-1:0] imm_q,  imm_d;
    logic [DLY_W-1:0] dly_q,  dly_d;
    logic [BIT_W-1:0] bit_q,  bit_d;
    logic [ATT_W-1:0] att_q,  att_d;
    logic [DAT_W-1:0] acc_q,  acc_d;
    logic [DAT_W-1:0] dat_q,  dat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             start;
    logic             finish;
    logic [31:0]      lfsr_step;
    logic [DAT_W-1:0] acc_shift;
    logic [DAT_W-1:0] mod_m1;
    logic [DAT_W-1:0] mask;
    logic [DAT_W-1:0] cand;

    assign start     = bus.t_cs & bus.ipt_wrp_to_prng_t_sel & ~t_sel_q & (fsm_q == S_IDLE);
    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 32'h0);
    assign acc_shift = {acc_q[DAT_W-2:0], lfsr_q[0]};

    // Smallest all-ones mask covering mod-1; it stays below 2*mod, so a
    // single subtract always brings a rejected candidate into range.
    always_comb begin
        mod_m1 = imm_q - IMM_W'(1);
        mask   = mod_m1;
        for (int s = 1; s < DAT_W; s = s * 2) begin
            mask = mask | (mask >> s);
        end
        cand = acc_q & mask;
    end

    always_comb begin
        fsm_d  = fsm_q;
        lfsr_d = lfsr_q;
        typ_d  = typ_q;
        imm_d  = imm_q;
        dly_d  = dly_q;
        bit_d  = bit_q;
        att_d  = att_q;
        acc_d  = acc_q;
        dat_d  = dat_q;
        busy_d = busy_q;
        done_d = 1'b0;
        finish = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    typ_d  = bus.ipt_wrp_to_prng_typ_sel;
                    imm_d  = bus.ipt_wrp_to_prng_t_dat;
                    dly_d  = bus.ipt_wrp_to_prng_delay;
                    bit_d  = '0;
                    att_d  = ATT_W'(1);
                    busy_d = 1'b1;
                    fsm_d  = (bus.ipt_wrp_to_prng_delay != '0) ? S_PRE : S_GEN;
                end
            end

            S_PRE: begin
                dly_d = dly_q - DLY_W'(1);
                if (dly_q == DLY_W'(1)) begin
                    fsm_d = S_GEN;
                end
            end

            S_GEN: begin
                if (typ_q == TYP_NOP) begin
                    finish = 1'b1;
                end else if (typ_q == TYP_SEED) begin
                    lfsr_d = {imm_q, imm_q ^ SEED_XOR};
                    finish = 1'b1;
                end else begin
                    lfsr_d = lfsr_step;
                    acc_d  = acc_shift;
                    bit_d  = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DAT_W - 1)) begin
                        bit_d = '0;
                        if (typ_q == TYP_RAND) begin
                            dat_d  = acc_shift;
                            finish = 1'b1;
                        end else begin
                            fsm_d = S_CHK;
                        end
                    end
                end
            end

            S_CHK: begin
                if (imm_q == '0) begin
                    dat_d  = acc_q;
                    finish = 1'b1;
                end else if (cand < imm_q) begin
                    dat_d  = cand;
                    finish = 1'b1;
                end else if (att_q < ATT_W'(RETRY_MAX)) begin
                    att_d = att_q + ATT_W'(1);
                    fsm_d = S_GEN;
                end else begin
                    dat_d  = cand - imm_q;
                    finish = 1'b1;
                end
            end

            default: fsm_d = S_IDLE;
        endcase

        if (finish) begin
            fsm_d  = S_IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            fsm_q   <= S_IDLE;
            lfsr_q  <= LFSR_RST;
            t_sel_q <= 1'b0;
            typ_q   <= '0;
            imm_q   <= '0;
            dly_q   <= '0;
            bit_q   <= '0;
            att_q   <= '0;
            acc_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            lfsr_q  <= lfsr_d;
            t_sel_q <= bus.ipt_wrp_to_prng_t_sel;
            typ_q   <= typ_d;
            imm_q   <= imm_d;
            dly_q   <= dly_d;
            bit_q   <= bit_d;
            att_q   <= att_d;
            acc_q   <= acc_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.opt_prng_to_wrp_dat = dat_q;
    assign bus.opt_prng_busy       = busy_q;
    assign bus.opt_prng_done       = done_q;
endmodule
`default_nettype wire
